// File: rtl/j1_io_pkg.sv
// ============================================================================
// j1_io_pkg : register map, STATUS bit positions and FSM states for j1_io_uart
// Revision  : 1.0
// ============================================================================
`default_nettype none

package j1_io_pkg;

  localparam logic [11:0] REG_DATA   = 12'd0;
  localparam logic [11:0] REG_STATUS = 12'd1;
  localparam logic [11:0] REG_DIV    = 12'd2;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_IDLE    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // A bit shorter than two clocks would leave no room for the RX half-bit sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/j1_uart_txfifo.sv
// ============================================================================
// j1_uart_txfifo : synchronous FIFO; pushes while full are dropped
// Revision       : 1.0
// ============================================================================
`default_nettype none

module j1_uart_txfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  // Full is judged on the registered count, so a simultaneous pop cannot make room.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/j1_io_uart.sv
// ============================================================================
// j1_io_uart : j1 IO-bus UART (DATA/STATUS/DIV), 8N1 TX with FIFO, optional RX
// Build macro: J1_UART_RX_EN enables the receive path.   Revision: 1.0
// ============================================================================
`default_nettype none

module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR    = 12'hF00,
  parameter logic [15:0] DIV_RESET    = 16'd434,
  parameter int          TXFIFO_DEPTH = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [11:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_txd_o,
  input  logic        uart_rxd_i
);

  logic [11:0] offset;
  logic        rd_en, wr_data, wr_div;
  logic [15:0] div_q, io_din_q, status, rdata;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_data;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ovr, rx_ferr;

  assign offset  = io_addr - BASE_ADDR;
  assign rd_en   = io_rd && !io_wr;
  assign wr_data = io_wr && (offset == REG_DATA);
  assign wr_div  = io_wr && (offset == REG_DIV);

  j1_uart_txfifo #(.WIDTH(8), .DEPTH(TXFIFO_DEPTH)) u_txfifo (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .push_i  (wr_data),
    .data_i  (io_dout[7:0]),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (fifo_data)
  );

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d, launch;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    fifo_pop   = 1'b0;
    launch     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d  = 1'b1;
        launch = !fifo_empty;
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = 3'd0;
          txd_d      = tx_sh_q[0];
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
          launch     = !fifo_empty;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Launching straight out of STOP gives back-to-back frames with no idle gap.
    if (launch) begin
      fifo_pop   = 1'b1;
      tx_sh_d    = fifo_data;
      tx_div_d   = div_q;
      tx_cnt_d   = div_q - 16'd1;
      txd_d      = 1'b0;
      tx_state_d = TX_START;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_RESET;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      div_q      <= DIV_RESET;
      io_din_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      if (wr_div) div_q <= clamp_div(io_dout);
      if (rd_en)  io_din_q <= rdata;
    end
  end

`ifdef J1_UART_RX_EN
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_data_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_valid_q, rx_ovr_q, rx_ferr_q;
  logic        rx_good, rx_bad, rd_data, rd_status;

  assign rd_data   = rd_en && (offset == REG_DATA);
  assign rd_status = rd_en && (offset == REG_STATUS);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_div_d   = div_q;
          rx_cnt_d   = (div_q >> 1) - 16'd1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s2_q) begin
            rx_cnt_d   = rx_div_q - 16'd1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end else rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = rx_div_q - 16'd1;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_good    = rx_s2_q;
          rx_bad     = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= uart_rxd_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      if (rx_good && !rx_valid_q) rx_data_q <= rx_sh_q;
      // Set terms are OR-ed last so a same-cycle read cannot swallow a new event.
      rx_valid_q <= (rx_valid_q && !rd_data) || (rx_good && !rx_valid_q);
      rx_ovr_q   <= (rx_ovr_q && !rd_status) || (rx_good && rx_valid_q);
      rx_ferr_q  <= (rx_ferr_q && !rd_status) || rx_bad;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_ovr   = rx_ovr_q;
  assign rx_ferr  = rx_ferr_q;
`else
  logic rxd_unused;
  assign rxd_unused = uart_rxd_i;
  assign rx_data    = 8'h00;
  assign rx_valid   = 1'b0;
  assign rx_ovr     = 1'b0;
  assign rx_ferr    = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_IDLE]    = fifo_empty && (tx_state_q == TX_IDLE);
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_ovr;
    status[ST_FRAME_ERR]  = rx_ferr;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      REG_DATA:   rdata = {8'h00, rx_data};
      REG_STATUS: rdata = status;
      REG_DIV:    rdata = div_q;
      default:    rdata = '0;
    endcase
  end

  assign io_din     = io_din_q;
  assign uart_txd_o = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_j1_io_uart.sv
// ============================================================================
// tb_j1_io_uart : scoreboard bench for j1_io_uart (register reads and TX frames)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_j1_io_uart;

  localparam logic [11:0] BASE  = 12'hF00;
  localparam int          DEPTH = 4;
`ifdef J1_UART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, io_rd = 1'b0, io_wr = 1'b0, rxd = 1'b1;
  logic [11:0] io_addr = '0;
  logic [15:0] io_dout = '0;
  logic [15:0] io_din;
  logic        txd;

  always #5 clk = ~clk;

  j1_io_uart #(.BASE_ADDR(BASE), .DIV_RESET(16'd434), .TXFIFO_DEPTH(DEPTH)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .uart_txd_o(txd),
    .uart_rxd_i(rxd)
  );

  int n_checks = 0, n_pass = 0;
  int model_div = 434;
  int m_pending = 0;
  int frames_seen = 0;
  logic [7:0] tx_exp_q[$];
  logic m_rxv = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_rxd = 8'h00;
  logic tx_mon_en = 1'b1;
  typedef struct {string nm; logic [15:0] v;} rd_exp_t;
  rd_exp_t rd_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  function automatic logic [15:0] status_exp();
    logic [15:0] s;
    s    = '0;
    s[0] = (m_pending > DEPTH);
    s[1] = (m_pending == 0);
    s[2] = m_rxv;
    s[3] = m_ovr;
    s[4] = m_ferr;
    return s;
  endfunction

  task automatic wr(input logic [1:0] off, input logic [15:0] d);
    io_wr = 1'b1; io_addr = BASE + {10'b0, off}; io_dout = d;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    if (m_pending < DEPTH + 1) begin
      tx_exp_q.push_back(b);
      m_pending++;
    end
    wr(2'd0, {$urandom_range(0, 255)} [7:0] == 8'h00 ? {8'h5A, b} : {8'hA5, b});
  endtask

  task automatic set_div(input logic [15:0] d);
    model_div = (d < 16'd2) ? 2 : int'(d);
    wr(2'd2, d);
  endtask

  task automatic rd(input string nm, input logic [1:0] off, input logic [15:0] exp);
    rd_exp_t e;
    e.nm = nm; e.v = exp;
    rd_q.push_back(e);
    io_rd = 1'b1; io_addr = BASE + {10'b0, off};
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic rd_status(input string nm);
    logic [15:0] e;
    e = status_exp();
    m_ovr = 1'b0; m_ferr = 1'b0;
    rd(nm, 2'd1, e);
  endtask

  task automatic rd_data(input string nm);
    logic [15:0] e;
    e = RX_EN ? {8'h00, m_rxd} : 16'h0000;
    m_rxv = 1'b0;
    rd(nm, 2'd0, e);
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 5000 && m_pending != 0; i++) @(negedge clk);
    chk("tx_drain_pending", m_pending, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (model_div) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (3 * model_div) @(negedge clk);
    if (!stop) m_ferr = 1'b1;
    else if (!m_rxv) begin m_rxv = 1'b1; m_rxd = b; end
    else m_ovr = 1'b1;
  endtask

  // Read-data monitor: one registered response per accepted read strobe.
  initial begin : rd_mon
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (io_rd && !io_wr && !rst) begin
        @(negedge clk);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          chk(e.nm, io_din, e.v);
        end else chk("rd_q_nonempty", rd_q.size(), 1);
      end
    end
  end

  // Serial monitor: every line cycle of a frame must equal the expected 8N1 level.
  initial begin : tx_mon
    logic       prev, ok, abort;
    logic [9:0] fr, act;
    logic [7:0] b;
    int         d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && prev && !txd) begin
        d = model_div;
        b = 8'h00;
        if (tx_exp_q.size() != 0) b = tx_exp_q.pop_front();
        else chk("tx_q_nonempty", tx_exp_q.size(), 1);
        fr = {1'b1, b, 1'b0};
        ok = 1'b1; abort = 1'b0; act = '0;
        for (int bi = 0; bi < 10; bi++) begin
          for (int c = 0; c < d; c++) begin
            if (!(bi == 0 && c == 0)) @(negedge clk);
            if (!tx_mon_en) abort = 1'b1;
            if (txd !== fr[bi]) ok = 1'b0;
            if (c == d / 2) act[bi] = txd;
          end
        end
        if (!abort) begin
          chk("tx_frame", {ok, act}, {1'b1, fr});
          frames_seen++;
          m_pending--;
        end
        prev = 1'b1;
      end else prev = txd;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int f0, g, sel;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_din", io_din, 0);
    rd_status("reset_status");
    rd("reset_div", 2'd2, 16'd434);

    set_div(16'd1);  rd("div_clamp1", 2'd2, 16'(model_div));
    set_div(16'd0);  rd("div_clamp0", 2'd2, 16'(model_div));
    set_div(16'd4);  rd("div_4", 2'd2, 16'(model_div));
    rd("unmapped_rd", 2'd3, 16'h0000);
    wr(2'd3, 16'hFFFF);
    rd("div_after_unmapped_wr", 2'd2, 16'(model_div));

    // Single frame: latency to start bit and exact tx_idle return.
    tx_byte(8'hA5);
    chk("txd_before_fall", txd, 1);
    @(negedge clk);
    chk("txd_fall", txd, 0);
    repeat (38) @(negedge clk);
    rd_status("status_busy_end");
    @(negedge clk);
    rd_status("status_idle_again");
    wait_tx_idle();

    // FIFO full: 5 back-to-back bytes fit, the 6th is dropped.
    f0 = frames_seen;
    for (int i = 0; i < 5; i++) tx_byte(8'($urandom));
    rd_status("status_full");
    tx_byte(8'($urandom));
    wait_tx_idle();
    chk("frame_count_full", frames_seen - f0, 5);

    // DIV change mid-frame applies from the next frame.
    tx_byte(8'($urandom));
    tx_byte(8'($urandom));
    repeat (8) @(negedge clk);
    set_div(16'd8);
    wait_tx_idle();
    rd("div_8", 2'd2, 16'd8);
    set_div(16'd4);

    // Randomised traffic at several divisors.
    for (int k = 0; k < 3; k++) begin
      set_div(16'($urandom_range(2, 6)));
      for (int j = 0; j < 6; j++) begin
        for (int t = 0; t < 2000 && m_pending > 3; t++) @(negedge clk);
        tx_byte(8'($urandom));
        g = $urandom_range(0, 30);
        repeat (g) @(negedge clk);
      end
      wait_tx_idle();
    end
    set_div(16'd4);

    if (RX_EN) begin
      rx_frame(8'h3C, 1'b1); rd_status("rx_valid");
      rx_frame(8'h81, 1'b1); rd_status("rx_overrun");
      rd_data("rx_data_3c");
      rx_frame(8'h5B, 1'b0); rd_status("rx_frame_err");
      rd_status("rx_flags_cleared");
      for (int k = 0; k < 8; k++) begin
        rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 2);
        if (sel == 0) rd_data("rx_rand_data");
        else if (sel == 1) rd_status("rx_rand_status");
      end
      rd_data("rx_final_data");
      rd_status("rx_final_status");
    end else begin
      rd_data("data_rx_disabled");
      rd_status("status_rx_disabled");
    end

    // Reset in the middle of an all-zero data byte.
    tx_byte(8'h00);
    repeat (12) @(negedge clk);
    chk("pre_reset_txd", txd, 0);
    tx_mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_tx_txd", txd, 1);
    rst = 1'b0;
    model_div = 434; m_pending = 0; tx_exp_q.delete();
    m_rxv = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_rxd = 8'h00;
    @(negedge clk);
    rd_status("status_after_rst");
    rd("div_after_rst", 2'd2, 16'd434);
    repeat (60) @(negedge clk);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/j1_io_uart.md
# j1_io_uart

Memory-mapped UART responder on the j1 CPU IO bus: the peripheral end of the j1 `io_rd`/`io_wr`/`io_addr`/`io_dout`/`io_din` interface. It decodes CPU IO accesses at a parameterised base address and serialises written bytes as 8N1 frames. It returns received bytes and status to the CPU over `io_din`. It sits beside the j1 core in the top level, wired directly to the core's IO nets.

## Interface
- `BASE_ADDR`, 12'hF00: IO address of register 0. The block decodes `BASE_ADDR+0..+2`.
- `DIV_RESET`, 16'd434: reset value of the baud divisor, in clocks per bit.
- `TXFIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2.
- `sys_clk_i` in 1: the single clock.
- `sys_rst_i` in 1: reset, synchronous, active-high.
- `io_rd` in 1: CPU read strobe, one cycle.
- `io_wr` in 1: CPU write strobe, one cycle.
- `io_addr` in 12: CPU IO address.
- `io_dout` in 16: CPU write data. Only bits [7:0] are used for DATA.
- `io_din` out 16: read data to the CPU.
- `uart_txd_o` out 1: serial TX, idle high.
- `uart_rxd_i` in 1: serial RX, asynchronous.

## Operation
- **Register map**
  - +0 DATA. A write pushes `io_dout[7:0]` into the TX FIFO. A read pops the RX holding register.
  - +1 STATUS, read-only. Bit0 tx_full, bit1 tx_idle (FIFO empty and shifter idle), bit2 rx_valid, bit3 rx_overrun, bit4 frame_err. All other bits read 0.
  - +2 DIV, read/write, 16 bits.
  - Reads of unmapped offsets return 0. Writes to unmapped offsets are ignored.
- **TX FIFO**
  - A push while full is dropped silently; FIFO contents are unchanged.
  - The full flag is evaluated before any same-cycle pop by the shifter. A push and a pop in the same cycle while full drops the push.
- **TX FSM** (IDLE → START → DATA → STOP → IDLE)
  - In IDLE with the FIFO non-empty, the FSM pops one byte, latches DIV, and enters START.
  - The frame is 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). Each bit lasts exactly the latched DIV cycles.
  - Back-to-back frames: the next START follows STOP directly with no idle gap.
- **DIV rules**
  - A write to DIV takes effect at the next frame start, for both TX and RX.
  - Values below 2 are stored as 2.
- **RX FSM** (IDLE → START → DATA → STOP)
  - `uart_rxd_i` passes through a 2-flop synchroniser.
  - A falling edge in IDLE starts a frame. The start bit is resampled at DIV/2 cycles; if it is high, the FSM returns to IDLE.
  - Each data bit and the stop bit are sampled DIV cycles after the previous sample.
  - Stop bit 0: frame_err is set and the byte is discarded.
  - Good byte with rx_valid=0: the byte is loaded and rx_valid is set.
  - Good byte with rx_valid=1: the old byte is kept and rx_overrun is set.
- **Read side effects** (decided on the `io_rd` cycle)
  - DATA read clears rx_valid.
  - STATUS read clears rx_overrun and frame_err.
  - If a flag set and a clear happen in the same cycle, the set wins.

## Timing
- Reset values:
  - `io_din`=0 and `uart_txd_o`=1.
  - FIFO empty, both FSMs in IDLE.
  - All flags 0, DIV=`DIV_RESET`.
- Reset mid-frame: `uart_txd_o` returns high on the cycle after reset is sampled, and any partial RX byte is discarded.
- `io_din` is registered and valid on the cycle after `io_rd`. It holds that value until the next `io_rd`.
- Write to DATA at cycle N while idle:
  - FIFO non-empty at N+1.
  - `uart_txd_o` falls at N+2.
  - Stop bit ends at N+2+10·DIV.
- tx_idle deasserts at N+1 and reasserts at the end of the stop bit.
- RX: rx_valid rises 2 sync cycles plus 1 cycle after the mid-stop-bit sample.
- Simultaneous `io_rd` and `io_wr` cannot occur (guaranteed by the j1). If both are asserted, only the write is performed.

## Configuration
- `J1_UART_RX_EN` defined: the RX path, the synchroniser, and STATUS bits 2–4 are built.
- `J1_UART_RX_EN` undefined:
  - `uart_rxd_i` is present but ignored.
  - DATA reads return 0.
  - STATUS bits 2–4 read 0.
  - No RX logic is synthesised.

## Structure
- Package `j1_io_pkg` holds:
  - Register offsets (`REG_DATA`, `REG_STATUS`, `REG_DIV`).
  - STATUS bit positions.
  - TX/RX FSM state enums.
- One sub-module, `j1_uart_txfifo`: a synchronous FIFO with push, pop, full, empty and data outputs, parameterised by width and depth.

## Test plan
All scenarios use DIV=4 and BASE_ADDR=12'hF00.
- **Reset:** after reset, read STATUS (F01) → `io_din`=16'h0002, `uart_txd_o`=1; read DIV (F02) → 434 with default parameters.
- **TX frame:** write 8'hA5 to F00 → `uart_txd_o` falls 2 cycles later; bits sampled every 4 cycles read 0,1,0,1,0,0,1,0,1, then stop bit 1; tx_idle returns after 40 cycles.
- **TX FIFO full:** write 5 bytes back-to-back while the shifter holds the first → exactly 5 frames, since the 4 FIFO entries plus the shifter absorb all 5. A 6th write before the first frame ends is dropped, and STATUS bit0=1 before the drop.
- **RX good/overrun:** drive 8'h3C, then read STATUS → 16'h0004 (rx_valid). Drive 8'h81 without reading DATA, then read STATUS → 16'h000C. Read DATA → 16'h003C.
- **RX frame error:** drive a frame with stop bit 0 → STATUS=16'h0010 and rx_valid=0. A second STATUS read → 16'h0000.
- **Edge cases:**
  - Write DIV=1 → reads back 2.
  - Write DIV=8 mid-frame → the current frame keeps 4-cycle bits; the next frame uses 8.
  - Assert reset mid-TX → `uart_txd_o`=1 on the next cycle.
